// File: rtl/npc_unit.sv
// Fetch-PC register and next-PC selector for the 5-stage MIPS pipeline.
// Resolves D-stage branches/jumps, steers PC_F with delay-slot semantics and counts branches.
module npc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             d_valid,
    input  logic [31:0]      pc_d,
    input  logic [3:0]       br_op,
    input  logic             beq_f,
    input  logic             bne_f,
    input  logic             blez_f,
    input  logic             bgtz_f,
    input  logic             bltz_f,
    input  logic             bgez_f,
    input  logic [15:0]      imm16,
    input  logic [25:0]      instr_idx,
    input  logic [31:0]      rs_val,
    output logic [31:0]      pc_f,
    output logic [31:0]      link_addr,
    output logic             redirect,
    output logic             pc_misalign,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    logic [31:0]      r_pc_f;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic [31:0] w_pc_d_plus4;
    logic [31:0] w_pc_f_plus4;
    logic [31:0] w_tgt;
    logic [31:0] w_next_pc;
    logic        w_is_br;
    logic        w_take;
    logic        w_is_jmp;
    logic        w_redirect;

    function automatic logic [31:0] f_br_tgt(input logic [31:0] pc_plus4, input logic [15:0] imm);
        f_br_tgt = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] f_j_tgt(input logic [31:0] pc_plus4, input logic [25:0] idx);
        f_j_tgt = {pc_plus4[31:28], idx, 2'b00};
    endfunction

    assign w_pc_d_plus4 = pc_d + 32'd4;
    assign w_pc_f_plus4 = r_pc_f + 32'd4;

    // Decode the D-stage control transfer; opcodes 11..15 and bubbles fall through as "none".
    always_comb begin
        w_is_br  = 1'b0;
        w_take   = 1'b0;
        w_is_jmp = 1'b0;
        w_tgt    = w_pc_f_plus4;
        if (d_valid) begin
            case (br_op)
                4'd1: begin w_is_br = 1'b1; w_take = beq_f;  w_tgt = f_br_tgt(w_pc_d_plus4, imm16); end
                4'd2: begin w_is_br = 1'b1; w_take = bne_f;  w_tgt = f_br_tgt(w_pc_d_plus4, imm16); end
                4'd3: begin w_is_br = 1'b1; w_take = blez_f; w_tgt = f_br_tgt(w_pc_d_plus4, imm16); end
                4'd4: begin w_is_br = 1'b1; w_take = bgtz_f; w_tgt = f_br_tgt(w_pc_d_plus4, imm16); end
                4'd5: begin w_is_br = 1'b1; w_take = bltz_f; w_tgt = f_br_tgt(w_pc_d_plus4, imm16); end
                4'd6: begin w_is_br = 1'b1; w_take = bgez_f; w_tgt = f_br_tgt(w_pc_d_plus4, imm16); end
                4'd7, 4'd8: begin w_is_jmp = 1'b1; w_tgt = f_j_tgt(w_pc_d_plus4, instr_idx); end
                4'd9, 4'd10: begin w_is_jmp = 1'b1; w_tgt = rs_val; end
                default: begin
                    w_is_br  = 1'b0;
                    w_take   = 1'b0;
                    w_is_jmp = 1'b0;
                    w_tgt    = w_pc_f_plus4;
                end
            endcase
        end else begin
            w_is_br = 1'b0;
        end
    end

    assign w_redirect = w_take | w_is_jmp;
    assign w_next_pc  = w_redirect ? w_tgt : w_pc_f_plus4;

    // PC_F and statistics advance only on unstalled cycles; the delay slot is never squashed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc_f      <= RESET_PC;
            r_br_cnt    <= {CNT_W{1'b0}};
            r_taken_cnt <= {CNT_W{1'b0}};
        end else if (!stall) begin
            r_pc_f      <= w_next_pc;
            r_br_cnt    <= r_br_cnt + {{(CNT_W-1){1'b0}}, w_is_br};
            r_taken_cnt <= r_taken_cnt + {{(CNT_W-1){1'b0}}, w_take};
        end else begin
            r_pc_f      <= r_pc_f;
            r_br_cnt    <= r_br_cnt;
            r_taken_cnt <= r_taken_cnt;
        end
    end

    assign pc_f        = r_pc_f;
    assign br_cnt      = r_br_cnt;
    assign taken_cnt   = r_taken_cnt;
    assign redirect    = w_redirect;
    assign link_addr   = pc_d + 32'd8;
    assign pc_misalign = (r_pc_f[1:0] != 2'b00);

endmodule
